// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the Booth multiplier controller
// Contents:
//   booth_state_t : controller FSM state encoding
//   N_ITER        : default number of Booth iterations (equals the operand width)
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } booth_state_t;

  localparam int N_ITER = 16;

endpackage

// File: rtl/iter_counter.sv
// rtl/iter_counter.sv - Booth iteration counter with clear, enable and terminal count
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : synchronous clear (wins over en)
//   en         : count up by one
//   count      : iterations completed so far
//   tc         : high while count == N_ITER-1 (last iteration in progress)
module iter_counter
  import booth_pkg::*;
#(
  parameter int WIDTH_CO = 5,
  parameter int N_ITER_P = N_ITER
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                en,
  output logic [WIDTH_CO-1:0] count,
  output logic                tc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == WIDTH_CO'(N_ITER_P - 1));

endmodule

// File: rtl/booth_controller.sv
// rtl/booth_controller.sv - sequencing FSM for the radix-2 Booth multiplier datapath
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (operands captured in the handshake cycle)
//   out_valid / out_ready: product handshake
//   abort                : synchronous cancel of the operation in flight
//   en_i, valid_in       : operand load / datapath counter load pulse (Mealy, on accept)
//   en_pp                : partial-product iteration enable (every ITER cycle)
//   en_fp                : final-product register enable (the single FINAL cycle)
//   busy                 : high in ITER or FINAL
//   iter_cnt             : iterations completed in the current operation
module booth_controller
  import booth_pkg::*;
#(
  parameter int WIDTH_IN = N_ITER,
  parameter int WIDTH_CO = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                abort,
  output logic                en_i,
  output logic                valid_in,
  output logic                en_pp,
  output logic                en_fp,
  output logic                busy,
  output logic [WIDTH_CO-1:0] iter_cnt
);

  booth_state_t state;
  booth_state_t state_nxt;
  logic         accept;
  logic         cnt_tc;

  // DONE releases its slot in the same cycle the consumer takes the product,
  // which is what allows back-to-back operations without an IDLE bubble.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready && !abort;

  assign en_i      = accept;
  assign valid_in  = accept;
  assign en_pp     = (state == ITER);
  // en_fp is Moore: an abort during FINAL still shows the pulse, but DONE is
  // never entered so the captured product is never presented.
  assign en_fp     = (state == FINAL);
  assign out_valid = (state == DONE);
  assign busy      = (state == ITER) || (state == FINAL);

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = ITER;
        ITER:    if (cnt_tc) state_nxt = FINAL;
        FINAL:   state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = accept ? ITER : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter restarts on every accepted operation and on abort; it only runs in ITER.
  iter_counter #(
    .WIDTH_CO (WIDTH_CO),
    .N_ITER_P (WIDTH_IN)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clear (accept || abort),
    .en    (state == ITER),
    .count (iter_cnt),
    .tc    (cnt_tc)
  );

endmodule

// File: tb/tb_booth_controller.sv
// tb/tb_booth_controller.sv - self-checking bench for booth_controller with a Booth datapath model
module tb_booth_controller;

  localparam int WIDTH_IN = 16;
  localparam int WIDTH_CO = 5;
  localparam int LAT      = WIDTH_IN + 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic                abort;
  logic                en_i;
  logic                valid_in;
  logic                en_pp;
  logic                en_fp;
  logic                busy;
  logic [WIDTH_CO-1:0] iter_cnt;

  logic [15:0] op_a;
  logic [15:0] op_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  booth_controller #(.WIDTH_IN(WIDTH_IN), .WIDTH_CO(WIDTH_CO)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .abort     (abort),
    .en_i      (en_i),
    .valid_in  (valid_in),
    .en_pp     (en_pp),
    .en_fp     (en_fp),
    .busy      (busy),
    .iter_cnt  (iter_cnt)
  );

  // Radix-2 Booth datapath driven only by the controller enables.
  logic signed [16:0] acc;
  logic signed [16:0] sum;
  logic [15:0]        mc;
  logic [15:0]        q;
  logic               q1;
  logic [31:0]        prod;

  always @(posedge clk) begin
    if (en_i) begin
      mc  <= op_a;
      q   <= op_b;
      q1  <= 1'b0;
      acc <= '0;
    end else if (en_pp) begin
      sum = acc;
      case ({q[0], q1})
        2'b01:   sum = acc + $signed({mc[15], mc});
        2'b10:   sum = acc - $signed({mc[15], mc});
        default: sum = acc;
      endcase
      {acc, q, q1} <= {sum[16], sum, q};
    end
    if (en_fp) prod <= {acc[15:0], q};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every consumed product is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      check("one_enable", 32'($countones({en_i, en_pp, en_fp}) <= 1), 32'd1);
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) check("scoreboard_empty", 32'd0, 32'd1);
        else check("product", prod, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p);
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    check("hs_in_ready", 32'(in_ready), 32'd1);
    check("hs_en_i_valid_in", 32'({en_i, valid_in}), 32'd3);
    exp_q.push_back(p);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input bit noise);
    int npp;
    int nfp;
    int lat;
    bit stray;
    npp = 0; nfp = 0; lat = 0; stray = 1'b0;
    if (noise) in_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (en_pp) npp++;
      if (en_fp) nfp++;
      if (busy && (in_ready || en_i)) stray = 1'b1;
      if (out_valid) begin
        lat = k;
        break;
      end
      cyc();
    end
    in_valid = 1'b0;
    check("en_pp_cycles", 32'(npp), 32'(WIDTH_IN));
    check("en_fp_cycles", 32'(nfp), 32'd1);
    check("out_valid_latency", 32'(lat), 32'(LAT));
    check("ignored_in_valid", 32'(stray), 32'd0);
  endtask

  task automatic hold(input int n, input logic [31:0] p);
    for (int i = 0; i < n; i++) begin
      cyc();
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_product", prod, p);
    end
  endtask

  task automatic consume();
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    check("consume_in_ready", 32'(in_ready), 32'd1);
    cyc();
    out_ready = 1'b0;
    @(negedge clk);
    check("post_consume_idle", 32'({out_valid, busy, in_ready}), 32'd1);
  endtask

  task automatic wait_cnt(input int target, output bit found);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (iter_cnt == WIDTH_CO'(target) && busy) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    int          bp;
    bit          noise;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bit seen;

    vecs[0] = '{16'd3,      16'd5,      32'h0000000F, 0,  1'b0};
    vecs[1] = '{16'hFFF9,   16'd3,      32'hFFFFFFEB, 10, 1'b0};
    vecs[2] = '{16'h7FFF,   16'h8000,   32'hC0008000, 0,  1'b1};
    vecs[3] = '{16'hFFFF,   16'h0001,   32'hFFFFFFFF, 2,  1'b0};
    vecs[4] = '{16'h0000,   16'h1234,   32'h00000000, 0,  1'b1};
    vecs[5] = '{16'hFFFF,   16'hFFFF,   32'h00000001, 0,  1'b0};
    vecs[6] = '{16'h1234,   16'h0010,   32'h00012340, 0,  1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          32'({in_ready, out_valid, en_i, valid_in, en_pp, en_fp, busy, iter_cnt}), 32'h800);

    for (int i = 0; i < 7; i++) begin
      cyc();
      handshake(vecs[i].a, vecs[i].b, vecs[i].p);
      wait_result(vecs[i].noise);
      if (vecs[i].bp > 0) hold(vecs[i].bp, vecs[i].p);
      consume();
    end

    // Back-to-back: second operands accepted in DONE while the first is consumed.
    cyc();
    handshake(16'd100, 16'hFFFD, 32'hFFFFFED4);
    wait_result(1'b0);
    cyc();
    out_ready = 1'b1;
    handshake(16'h8000, 16'h8000, 32'h40000000);
    out_ready = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_result(1'b0);
    consume();

    // Abort at iter_cnt == 7.
    cyc();
    handshake(16'd9, 16'd9, 32'd81);
    wait_cnt(7, found);
    check("abort_reached_cnt7", 32'(found), 32'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    @(negedge clk);
    check("abort_state", 32'({busy, en_pp, in_ready, iter_cnt}), 32'h20);
    void'(exp_q.pop_back());
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      @(negedge clk);
      if (en_fp || out_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    cyc();
    handshake(16'd2, 16'd2, 32'd4);
    wait_result(1'b0);
    consume();

    // Reset at iter_cnt == 10.
    cyc();
    handshake(16'd11, 16'd13, 32'd143);
    wait_cnt(10, found);
    check("reset_reached_cnt10", 32'(found), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("midop_reset_outputs",
          32'({in_ready, out_valid, en_i, valid_in, en_pp, en_fp, busy, iter_cnt}), 32'h800);
    void'(exp_q.pop_back());

    // Abort together with in_valid in IDLE.
    cyc();
    op_a = 16'd5; op_b = 16'd5;
    in_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    check("abort_vs_accept_en_i", 32'({en_i, valid_in}), 32'd0);
    cyc();
    in_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_vs_accept_idle", 32'({busy, out_valid, en_pp, in_ready}), 32'd1);

    // Reset and abort together mid-ITER.
    cyc();
    handshake(16'd6, 16'd7, 32'd42);
    wait_cnt(4, found);
    check("rst_abort_reached_cnt4", 32'(found), 32'd1);
    reset = 1'b1; abort = 1'b1;
    cyc();
    reset = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("reset_abort_outputs",
          32'({in_ready, out_valid, en_i, valid_in, en_pp, en_fp, busy, iter_cnt}), 32'h800);
    void'(exp_q.pop_back());

    cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
